// File: rtl/dzcpu_useq_pkg.sv
// dzcpu_useq_pkg: shared encodings for the dzcpu microcode sequencer.
// Holds the state, CTL and COND encodings, micro-op field positions and flag bit indices.
package dzcpu_useq_pkg;

    // Sequencer states; the numeric values are visible on oState.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_RUN   = 3'd2,
        ST_END   = 3'd3,
        ST_HALT  = 3'd4
    } state_e;

    // Micro-op CTL field: how the micro-PC moves after this micro-op.
    typedef enum logic [2:0] {
        CTL_NEXT = 3'd0,
        CTL_EOF  = 3'd1,
        CTL_EOFC = 3'd2,
        CTL_BR   = 3'd3,
        CTL_CALL = 3'd4,
        CTL_RET  = 3'd5,
        CTL_JTAB = 3'd6,
        CTL_HALT = 3'd7
    } ctl_e;

    // Micro-op COND field: the flag test used by EOFC and BR.
    typedef enum logic [2:0] {
        COND_ALWAYS = 3'd0,
        COND_Z      = 3'd1,
        COND_NZ     = 3'd2,
        COND_C      = 3'd3,
        COND_NC     = 3'd4,
        COND_N      = 3'd5,
        COND_H      = 3'd6,
        COND_NEVER  = 3'd7
    } cond_e;

    // Bit positions inside iFlags = {Z,N,H,C}.
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_H = 1;
    localparam int FLAG_C = 0;

    // Field positions as functions of the micro-op width.
    function automatic int uop_ipc_bit(input int uop_w);
        return uop_w - 1;
    endfunction

    function automatic int uop_ctl_lsb(input int uop_w);
        return uop_w - 4;
    endfunction

    function automatic int uop_cond_lsb(input int uop_w);
        return uop_w - 7;
    endfunction

    // Evaluate a COND code against the current flags.
    function automatic logic cond_true(input cond_e c, input logic [3:0] f);
        logic r;
        r = 1'b0;
        unique case (c)
            COND_ALWAYS: r = 1'b1;
            COND_Z:      r = f[FLAG_Z];
            COND_NZ:     r = ~f[FLAG_Z];
            COND_C:      r = f[FLAG_C];
            COND_NC:     r = ~f[FLAG_C];
            COND_N:      r = f[FLAG_N];
            COND_H:      r = f[FLAG_H];
            COND_NEVER:  r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dzcpu_useq_stack.sv
// dzcpu_useq_stack: LIFO holding micro-call return addresses.
// Ports: iClock/iReset, iClear (sync pointer clear), iPush/iPushData, iPop, oTop, oFull, oEmpty.
module dzcpu_useq_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             iClock,
    input  logic             iReset,
    input  logic             iClear,
    input  logic             iPush,
    input  logic [WIDTH-1:0] iPushData,
    input  logic             iPop,
    output logic [WIDTH-1:0] oTop,
    output logic             oFull,
    output logic             oEmpty
);

    // Pointer counts entries (0..DEPTH); entries are indexed with IDX_W bits.
    localparam int SP_W  = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [SP_W-1:0]  sp_q;
    logic [SP_W-1:0]  sp_d;
    logic [WIDTH-1:0] mem_q [2**IDX_W];
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic             do_push;
    logic             do_pop;

    assign oFull  = (sp_q == SP_W'(DEPTH));
    assign oEmpty = (sp_q == '0);

    assign do_push = iPush & ~oFull;
    assign do_pop  = iPop & ~oEmpty;

    // Truncation is safe: writes happen only below DEPTH, reads only above 0.
    assign wr_idx = IDX_W'(sp_q);
    assign rd_idx = IDX_W'(sp_q - 1'b1);

    assign oTop = oEmpty ? '0 : mem_q[rd_idx];

    always_comb begin
        sp_d = sp_q;
        if (iClear) begin
            sp_d = '0;
        end else if (do_push) begin
            sp_d = sp_q + 1'b1;
        end else if (do_pop) begin
            sp_d = sp_q - 1'b1;
        end
    end

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    // Storage needs no reset: only entries below the pointer are ever read.
    always_ff @(posedge iClock) begin
        if (do_push && !iClear) begin
            mem_q[wr_idx] <= iPushData;
        end
    end

endmodule

// File: rtl/dzcpu_useq.sv
// dzcpu_useq: microcode sequencer (uPC, flow start, branches, call stack, stall).
// Ports: iClock/iReset, iFlowIdx/iUop/iFlags/iStall in; oUpc/oUop/oUopValid/oIncPc/oState/oHalted/oStackErr out.
module dzcpu_useq
    import dzcpu_useq_pkg::*;
#(
    parameter int UPC_W       = 8,
    parameter int UOP_W       = 16,
    parameter int NUM_TABLES  = 2,
    parameter int STACK_DEPTH = 4
) (
    input  logic                        iClock,
    input  logic                        iReset,
    input  logic [NUM_TABLES*UPC_W-1:0] iFlowIdx,
    input  logic [UOP_W-1:0]            iUop,
    input  logic [3:0]                  iFlags,
    input  logic                        iStall,
    output logic [UPC_W-1:0]            oUpc,
    output logic [UOP_W-1:0]            oUop,
    output logic                        oUopValid,
    output logic                        oIncPc,
    output logic [2:0]                  oState,
    output logic                        oHalted,
    output logic                        oStackErr
);

    localparam int IPC_BIT  = uop_ipc_bit(UOP_W);
    localparam int CTL_LSB  = uop_ctl_lsb(UOP_W);
    localparam int COND_LSB = uop_cond_lsb(UOP_W);

    state_e           state_q;
    state_e           state_d;
    logic [UPC_W-1:0] upc_q;
    logic [UPC_W-1:0] upc_d;
    logic             err_q;
    logic             err_d;

    ctl_e             ctl;
    cond_e            cond;
    logic             cond_ok;
    logic [UPC_W-1:0] upc_inc;
    logic [UPC_W-1:0] tgt;
    logic [2:0]       jidx;
    logic             jidx_ok;
    logic [UPC_W-1:0] jtab_addr;
    logic             uop_valid;

    logic             stk_clr;
    logic             stk_push;
    logic             stk_pop;
    logic [UPC_W-1:0] stk_top;
    logic             stk_full;
    logic             stk_empty;

    // Micro-op field decode.
    assign ctl     = ctl_e'(iUop[CTL_LSB +: 3]);
    assign cond    = cond_e'(iUop[COND_LSB +: 3]);
    assign cond_ok = cond_true(cond, iFlags);
    assign tgt     = iUop[UPC_W-1:0];
    assign jidx    = iUop[2:0];
    assign jidx_ok = (int'(jidx) < NUM_TABLES);

    // Wraps modulo 2^UPC_W by construction.
    assign upc_inc = upc_q + 1'b1;

    // Flow-table select for JTAB; an out-of-range index yields 0 and halts.
    always_comb begin
        jtab_addr = '0;
        for (int t = 0; t < NUM_TABLES; t++) begin
            if (jidx == 3'(t)) begin
                jtab_addr = iFlowIdx[t*UPC_W +: UPC_W];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        upc_d     = upc_q;
        err_d     = err_q;
        stk_clr   = 1'b0;
        stk_push  = 1'b0;
        stk_pop   = 1'b0;
        uop_valid = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                state_d = ST_START;
            end

            ST_START: begin
                upc_d   = iFlowIdx[0 +: UPC_W];
                stk_clr = 1'b1;
                state_d = ST_RUN;
            end

            ST_RUN: begin
                // A stall freezes everything; the held micro-op runs later.
                if (!iStall) begin
                    uop_valid = !(ctl inside {CTL_BR, CTL_CALL, CTL_RET, CTL_JTAB});
                    unique case (ctl)
                        CTL_NEXT: begin
                            upc_d = upc_inc;
                        end
                        CTL_EOF: begin
                            state_d = ST_END;
                        end
                        CTL_EOFC: begin
                            if (cond_ok) begin
                                state_d = ST_END;
                            end else begin
                                upc_d = upc_inc;
                            end
                        end
                        CTL_BR: begin
                            upc_d = cond_ok ? tgt : upc_inc;
                        end
                        CTL_CALL: begin
                            if (stk_full) begin
                                err_d   = 1'b1;
                                state_d = ST_HALT;
                            end else begin
                                stk_push = 1'b1;
                                upc_d    = tgt;
                            end
                        end
                        CTL_RET: begin
                            if (stk_empty) begin
                                err_d   = 1'b1;
                                state_d = ST_HALT;
                            end else begin
                                stk_pop = 1'b1;
                                upc_d   = stk_top;
                            end
                        end
                        CTL_JTAB: begin
                            if (jidx_ok) begin
                                upc_d = jtab_addr;
                            end else begin
                                err_d   = 1'b1;
                                state_d = ST_HALT;
                            end
                        end
                        CTL_HALT: begin
                            state_d = ST_HALT;
                        end
                    endcase
                end
            end

            ST_END: begin
                state_d = ST_START;
            end

            ST_HALT: begin
                state_d = ST_HALT;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            state_q <= ST_IDLE;
            upc_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            upc_q   <= upc_d;
            err_q   <= err_d;
        end
    end

    dzcpu_useq_stack #(
        .WIDTH (UPC_W),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .iClock    (iClock),
        .iReset    (iReset),
        .iClear    (stk_clr),
        .iPush     (stk_push),
        .iPushData (upc_inc),
        .iPop      (stk_pop),
        .oTop      (stk_top),
        .oFull     (stk_full),
        .oEmpty    (stk_empty)
    );

    assign oUpc      = upc_q;
    assign oUop      = iUop;
    assign oUopValid = uop_valid;
    assign oIncPc    = uop_valid & iUop[IPC_BIT];
    assign oState    = state_q;
    assign oHalted   = (state_q == ST_HALT);
    assign oStackErr = err_q;

endmodule

// File: tb/tb_dzcpu_useq.sv
// tb_dzcpu_useq: directed and randomized checks of dzcpu_useq against a
// behavioural model (ROM and flow tables live in the bench).
module tb_dzcpu_useq;

    localparam int UPC_W = 8;
    localparam int UOP_W = 16;
    localparam int NT    = 2;
    localparam int SD    = 2;

    logic                  iClock = 1'b0;
    logic                  iReset = 1'b1;
    logic [NT*UPC_W-1:0]   iFlowIdx;
    logic [UOP_W-1:0]      iUop;
    logic [3:0]            iFlags = 4'h0;
    logic                  iStall = 1'b0;
    logic [UPC_W-1:0]      oUpc;
    logic [UOP_W-1:0]      oUop;
    logic                  oUopValid;
    logic                  oIncPc;
    logic [2:0]            oState;
    logic                  oHalted;
    logic                  oStackErr;

    logic [UOP_W-1:0] rom [256];
    logic [7:0]       flow0 = 8'h10;
    logic [7:0]       flow1 = 8'h80;

    assign iFlowIdx = {flow1, flow0};
    assign iUop     = rom[oUpc];

    always #5 iClock = ~iClock;

    dzcpu_useq #(
        .UPC_W       (UPC_W),
        .UOP_W       (UOP_W),
        .NUM_TABLES  (NT),
        .STACK_DEPTH (SD)
    ) dut (
        .iClock    (iClock),
        .iReset    (iReset),
        .iFlowIdx  (iFlowIdx),
        .iUop      (iUop),
        .iFlags    (iFlags),
        .iStall    (iStall),
        .oUpc      (oUpc),
        .oUop      (oUop),
        .oUopValid (oUopValid),
        .oIncPc    (oIncPc),
        .oState    (oState),
        .oHalted   (oHalted),
        .oStackErr (oStackErr)
    );

    // Model: states 0 idle, 1 start, 2 run, 3 end, 4 halt.
    int m_state;
    int m_upc;
    int m_stk[$];
    bit m_err;
    int ncmp = 0;
    int nfail = 0;

    function automatic logic [15:0] mk(input int ipc, input int ctl, input int cnd, input int tgt);
        logic [15:0] w;
        w = 16'h0;
        w[15]    = ipc[0];
        w[14:12] = ctl[2:0];
        w[11:9]  = cnd[2:0];
        w[7:0]   = tgt[7:0];
        return w;
    endfunction

    function automatic bit cond_ok(input int c, input logic [3:0] f);
        case (c)
            0: return 1'b1;
            1: return f[3];
            2: return !f[3];
            3: return f[0];
            4: return !f[0];
            5: return f[2];
            6: return f[1];
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cmp_all();
        logic [15:0] w;
        int ctl;
        bit v;
        w   = rom[m_upc];
        ctl = int'(w[14:12]);
        v   = (m_state == 2) && !iStall && !(ctl inside {3, 4, 5, 6});
        chk("upc", oUpc, m_upc);
        chk("state", oState, m_state);
        chk("valid", oUopValid, v);
        chk("incpc", oIncPc, v && w[15]);
        chk("halted", oHalted, m_state == 4);
        chk("stackerr", oStackErr, m_err);
        chk("uop", oUop, w);
    endtask

    task automatic model_step();
        logic [15:0] w;
        int ctl, cnd, tgt, nx, j;
        bit ok;
        case (m_state)
            0: m_state = 1;
            1: begin
                m_upc = int'(flow0);
                m_stk.delete();
                m_state = 2;
            end
            2: if (!iStall) begin
                w   = rom[m_upc];
                ctl = int'(w[14:12]);
                cnd = int'(w[11:9]);
                tgt = int'(w[7:0]);
                ok  = cond_ok(cnd, iFlags);
                nx  = (m_upc + 1) % 256;
                case (ctl)
                    0: m_upc = nx;
                    1: m_state = 3;
                    2: if (ok) m_state = 3; else m_upc = nx;
                    3: m_upc = ok ? tgt : nx;
                    4: if (m_stk.size() == SD) begin
                        m_err = 1'b1;
                        m_state = 4;
                    end else begin
                        m_stk.push_back(nx);
                        m_upc = tgt;
                    end
                    5: if (m_stk.size() == 0) begin
                        m_err = 1'b1;
                        m_state = 4;
                    end else begin
                        m_upc = m_stk.pop_back();
                    end
                    6: begin
                        j = tgt % 8;
                        if (j >= NT) begin
                            m_err = 1'b1;
                            m_state = 4;
                        end else begin
                            m_upc = (j == 0) ? int'(flow0) : int'(flow1);
                        end
                    end
                    default: m_state = 4;
                endcase
            end
            3: m_state = 1;
            default: ;
        endcase
    endtask

    // Called at a falling edge with inputs already driven.
    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            #1;
            cmp_all();
            model_step();
            @(posedge iClock);
            @(negedge iClock);
        end
    endtask

    // Asserts reset between edges, checks the asynchronous clear, releases at the next falling edge.
    task automatic reset_dut();
        iReset = 1'b1;
        m_state = 0;
        m_upc = 0;
        m_stk.delete();
        m_err = 1'b0;
        #1;
        chk("rst_upc", oUpc, 0);
        chk("rst_state", oState, 0);
        chk("rst_valid", oUopValid, 0);
        chk("rst_incpc", oIncPc, 0);
        chk("rst_halted", oHalted, 0);
        chk("rst_err", oStackErr, 0);
        @(negedge iClock);
        iReset = 1'b0;
    endtask

    task automatic fill_rom();
        for (int a = 0; a < 256; a++) rom[a] = mk(0, 1, 0, 0);
    endtask

    task automatic rand_rom();
        int r, ctl, tgt;
        for (int a = 0; a < 256; a++) begin
            r = $urandom_range(0, 99);
            if (r < 40) ctl = 0;
            else if (r < 55) ctl = 1;
            else if (r < 65) ctl = 2;
            else if (r < 78) ctl = 3;
            else if (r < 86) ctl = 4;
            else if (r < 94) ctl = 5;
            else if (r < 98) ctl = 6;
            else ctl = 7;
            tgt = (ctl == 6) ? $urandom_range(0, 3) : $urandom_range(0, 255);
            rom[a] = mk($urandom_range(0, 1), ctl, $urandom_range(0, 7), tgt);
        end
    endtask

    initial begin
        int inc;
        logic [2:0] st5;

        fill_rom();
        @(negedge iClock);

        // Basic flow: NEXT+IPC then EOF.
        flow0 = 8'h10;
        rom[8'h10] = mk(1, 0, 0, 0);
        rom[8'h11] = mk(0, 1, 0, 0);
        reset_dut();
        inc = 0;
        st5 = 3'd0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (oIncPc === 1'b1) inc++;
            if (c == 2) chk("t1_upc_c2", oUpc, 8'h10);
            if (c == 3) chk("t1_upc_c3", oUpc, 8'h11);
            if (c == 5) st5 = oState;
            cyc(1);
        end
        chk("t1_incpc_cnt", inc, 1);
        chk("t1_start_c5", st5, 1);

        // EOFC on Z: Z=0 falls through, Z=1 ends.
        fill_rom();
        rom[8'h10] = mk(0, 2, 1, 0);
        rom[8'h11] = mk(0, 1, 0, 0);
        iFlags = 4'b0000;
        reset_dut();
        cyc(3);
        #1 chk("t2_eofc_fall", oUpc, 8'h11);
        cyc(2);
        iFlags = 4'b1000;
        cyc(2);
        #1 chk("t2_eofc_end", oState, 3);
        cyc(1);

        // BR !C with C=1 falls through.
        rom[8'h10] = mk(0, 3, 4, 8'h40);
        iFlags = 4'b0001;
        reset_dut();
        cyc(3);
        #1 chk("t2_br_fall", oUpc, 8'h11);
        cyc(2);

        // Nested CALL/RET at full depth.
        fill_rom();
        iFlags = 4'b0000;
        rom[8'h10] = mk(0, 4, 0, 8'h20);
        rom[8'h11] = mk(1, 0, 0, 0);
        rom[8'h12] = mk(0, 1, 0, 0);
        rom[8'h20] = mk(0, 4, 0, 8'h30);
        rom[8'h21] = mk(0, 5, 0, 0);
        rom[8'h30] = mk(0, 5, 0, 0);
        reset_dut();
        cyc(5);
        #1 chk("t3_ret1", oUpc, 8'h21);
        cyc(1);
        #1 chk("t3_ret2", oUpc, 8'h11);
        cyc(3);

        // Third nested CALL overflows.
        rom[8'h30] = mk(0, 4, 0, 8'h50);
        reset_dut();
        cyc(5);
        #1 chk("t3_ovf_halt", oHalted, 1);
        chk("t3_ovf_err", oStackErr, 1);
        cyc(2);

        // JTAB to table 1, then an out-of-range table.
        fill_rom();
        flow1 = 8'h80;
        rom[8'h10] = mk(0, 6, 0, 1);
        rom[8'h80] = mk(0, 1, 0, 0);
        reset_dut();
        cyc(2);
        #1 chk("t4_jtab_valid", oUopValid, 0);
        cyc(1);
        #1 chk("t4_jtab_upc", oUpc, 8'h80);
        cyc(2);
        rom[8'h10] = mk(0, 6, 0, 3);
        reset_dut();
        cyc(3);
        #1 chk("t4_jbad_halt", oHalted, 1);
        chk("t4_jbad_err", oStackErr, 1);
        cyc(1);

        // Stall held three cycles on an EOF.
        fill_rom();
        rom[8'h10] = mk(1, 1, 0, 0);
        reset_dut();
        cyc(2);
        iStall = 1'b1;
        for (int s = 0; s < 3; s++) begin
            #1;
            chk("t5_stall_upc", oUpc, 8'h10);
            chk("t5_stall_valid", oUopValid, 0);
            cyc(1);
        end
        iStall = 1'b0;
        #1;
        chk("t5_exec_valid", oUopValid, 1);
        chk("t5_exec_incpc", oIncPc, 1);
        cyc(1);
        #1 chk("t5_end", oState, 3);
        cyc(1);

        // Reset mid-RUN with two stack entries.
        fill_rom();
        rom[8'h10] = mk(0, 4, 0, 8'h20);
        rom[8'h20] = mk(0, 4, 0, 8'h50);
        for (int a = 8'h50; a <= 8'h56; a++) rom[a] = mk(0, 0, 0, 0);
        reset_dut();
        cyc(9);
        #1 chk("t6_upc55", oUpc, 8'h55);
        reset_dut();
        rom[8'h10] = mk(0, 5, 0, 0);
        cyc(3);
        #1 chk("t6_ret_empty_err", oStackErr, 1);
        chk("t6_ret_empty_halt", oHalted, 1);
        cyc(1);

        // Randomized programs, flags and stalls.
        for (int it = 0; it < 30; it++) begin
            rand_rom();
            flow0 = 8'($urandom_range(0, 255));
            flow1 = 8'($urandom_range(0, 255));
            iStall = 1'b0;
            reset_dut();
            for (int c = 0; c < 50; c++) begin
                iFlags = 4'($urandom_range(0, 15));
                iStall = ($urandom_range(0, 3) == 0);
                cyc(1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
